// File: rtl/number_segment_draw.sv
// Seven-segment hex digit renderer for a 640x480 scan.
// A 16x32 box is placed at a shadow-latched top-left corner. Each cycle accepts
// one scan pixel, and the matching drawingRequest/RGBout appears 2 cycles later.
// Lit pixels are counted per frame, and the box is flagged when it is fully offscreen.
// Stream contract: there is no handshake. A pixel is accepted on every clk edge
// and is never stalled. startOfFrame is sampled on the same edge as the pixel.
module number_segment_draw #(
  parameter logic [7:0] OBJECT_COLOR = 8'h1C,
  parameter logic [7:0] TRANSPARENT  = 8'hFF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic [3:0]         digit,
  output logic               drawingRequest,
  output logic [7:0]         RGBout,
  output logic [9:0]         litCount,
  output logic               offScreen
);

  // Shadow copy of the placement, updated only at frame start.
  logic signed [10:0] r_shadow_x;
  logic signed [10:0] r_shadow_y;
  logic [3:0]         r_shadow_digit;
  logic               r_armed;   // shadows have been loaded at least once since reset
  logic               r_sof_d;   // frame start happened on the previous cycle

  // Stage 1: box-local coordinates and the segment mask that travels with them.
  logic               r_s1_inside;
  logic [3:0]         r_s1_ox;
  logic [4:0]         r_s1_oy;
  logic [6:0]         r_s1_mask;

  // Stage 2 outputs and frame statistics.
  logic               r_draw;
  logic [7:0]         r_rgb;
  logic [9:0]         r_count;
  logic [9:0]         r_lit_count;
  logic               r_off;

  logic signed [11:0] w_ox;
  logic signed [11:0] w_oy;
  logic               w_inside;
  logic [6:0]         w_mask;
  logic               w_hit;
  logic               w_off;

  // Box-local offsets. The 12-bit width keeps every 11-bit difference exact.
  assign w_ox = $signed({pixelX[10], pixelX}) - $signed({r_shadow_x[10], r_shadow_x});
  assign w_oy = $signed({pixelY[10], pixelY}) - $signed({r_shadow_y[10], r_shadow_y});
  assign w_inside = r_armed &&
                    (w_ox >= 12'sd0) && (w_ox <= 12'sd15) &&
                    (w_oy >= 12'sd0) && (w_oy <= 12'sd31);

  // Hex digit to gfedcba segment enables.
  always_comb begin
    w_mask = 7'h00;
    case (r_shadow_digit)
      4'h0: w_mask = 7'h3F;
      4'h1: w_mask = 7'h06;
      4'h2: w_mask = 7'h5B;
      4'h3: w_mask = 7'h4F;
      4'h4: w_mask = 7'h66;
      4'h5: w_mask = 7'h6D;
      4'h6: w_mask = 7'h7D;
      4'h7: w_mask = 7'h07;
      4'h8: w_mask = 7'h7F;
      4'h9: w_mask = 7'h6F;
      4'hA: w_mask = 7'h77;
      4'hB: w_mask = 7'h7C;
      4'hC: w_mask = 7'h39;
      4'hD: w_mask = 7'h5E;
      4'hE: w_mask = 7'h79;
      default: w_mask = 7'h71;
    endcase
  end

  // Segment hit test on the stage-1 coordinates. The segments overlap at their corners.
  always_comb begin
    w_hit = 1'b0;
    if (r_s1_mask[0] && r_s1_ox >= 4'd2  && r_s1_ox <= 4'd13 && r_s1_oy <= 5'd2)  w_hit = 1'b1;
    if (r_s1_mask[1] && r_s1_ox >= 4'd13 && r_s1_oy >= 5'd2  && r_s1_oy <= 5'd15) w_hit = 1'b1;
    if (r_s1_mask[2] && r_s1_ox >= 4'd13 && r_s1_oy >= 5'd16 && r_s1_oy <= 5'd29) w_hit = 1'b1;
    if (r_s1_mask[3] && r_s1_ox >= 4'd2  && r_s1_ox <= 4'd13 && r_s1_oy >= 5'd29) w_hit = 1'b1;
    if (r_s1_mask[4] && r_s1_ox <= 4'd2  && r_s1_oy >= 5'd16 && r_s1_oy <= 5'd29) w_hit = 1'b1;
    if (r_s1_mask[5] && r_s1_ox <= 4'd2  && r_s1_oy >= 5'd2  && r_s1_oy <= 5'd15) w_hit = 1'b1;
    if (r_s1_mask[6] && r_s1_ox >= 4'd2  && r_s1_ox <= 4'd13 && r_s1_oy >= 5'd14 && r_s1_oy <= 5'd17) w_hit = 1'b1;
  end

  // The box is fully outside the visible 640x480 area.
  assign w_off = ($signed({r_shadow_x[10], r_shadow_x}) + 12'sd15 < 12'sd0) ||
                 ($signed({r_shadow_x[10], r_shadow_x}) > 12'sd639) ||
                 ($signed({r_shadow_y[10], r_shadow_y}) + 12'sd31 < 12'sd0) ||
                 ($signed({r_shadow_y[10], r_shadow_y}) > 12'sd479);

  // Latch the placement at frame start so that mid-frame input changes cannot tear the image.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shadow_x     <= '0;
      r_shadow_y     <= '0;
      r_shadow_digit <= '0;
      r_armed        <= 1'b0;
      r_sof_d        <= 1'b0;
    end else begin
      r_sof_d <= startOfFrame;
      if (startOfFrame) begin
        r_shadow_x     <= topLeftX;
        r_shadow_y     <= topLeftY;
        r_shadow_digit <= digit;
        r_armed        <= 1'b1;
      end
    end
  end

  // Two-stage render pipeline. The mask is carried along so that in-flight pixels keep their digit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_inside <= 1'b0;
      r_s1_ox     <= '0;
      r_s1_oy     <= '0;
      r_s1_mask   <= '0;
      r_draw      <= 1'b0;
      r_rgb       <= TRANSPARENT;
    end else begin
      r_s1_inside <= w_inside;
      r_s1_ox     <= w_ox[3:0];
      r_s1_oy     <= w_oy[4:0];
      r_s1_mask   <= w_mask;
      r_draw      <= r_s1_inside && w_hit;
      r_rgb       <= (r_s1_inside && w_hit) ? OBJECT_COLOR : TRANSPARENT;
    end
  end

  // Saturating lit-pixel counter. A lit pixel on the frame-start cycle opens the new frame's count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count     <= '0;
      r_lit_count <= '0;
    end else if (startOfFrame) begin
      r_lit_count <= r_count;
      r_count     <= r_draw ? 10'd1 : 10'd0;
    end else if (r_draw && (r_count != 10'h3FF)) begin
      r_count <= r_count + 10'd1;
    end
  end

  // Offscreen flag, evaluated once the new shadow values are in place.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_off <= 1'b0;
    else if (r_sof_d) r_off <= w_off;
  end

  assign drawingRequest = r_draw;
  assign RGBout         = r_rgb;
  assign litCount       = r_lit_count;
  assign offScreen      = r_off;

endmodule

// File: tb/tb_number_segment_draw.sv
// Bench for number_segment_draw: a reference model built on segment rectangles and a delay queue.
module tb_number_segment_draw;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic signed [10:0] pixelX = '0;
  logic signed [10:0] pixelY = '0;
  logic signed [10:0] topLeftX = '0;
  logic signed [10:0] topLeftY = '0;
  logic [3:0]         digit = '0;
  logic               drawingRequest;
  logic [7:0]         RGBout;
  logic [9:0]         litCount;
  logic               offScreen;

  number_segment_draw dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .digit(digit), .drawingRequest(drawingRequest), .RGBout(RGBout),
    .litCount(litCount), .offScreen(offScreen)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference tables: the digit masks and the segment rectangles a..g.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int sx0 [7] = '{2, 13, 13,  2,  0,  0,  2};
  int sx1 [7] = '{13, 15, 15, 13,  2,  2, 13};
  int sy0 [7] = '{0,  2, 16, 29, 16,  2, 14};
  int sy1 [7] = '{2, 15, 29, 31, 29, 15, 17};

  // Model state
  int  m_sx, m_sy, m_dig, m_cnt, m_lit;
  bit  m_armed, m_off, m_sofd, m_out;
  logic [0:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_lit(input int ox, input int oy, input int dig);
    bit r = 0;
    if (ox < 0 || ox > 15 || oy < 0 || oy > 31) return 0;
    for (int s = 0; s < 7; s++)
      if (seg_tab[dig][s] && ox >= sx0[s] && ox <= sx1[s] && oy >= sy0[s] && oy <= sy1[s]) r = 1;
    return r;
  endfunction

  function automatic int count_box(input int dig);
    int n = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 16; x++)
        if (model_lit(x, y, dig)) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_dig = 0; m_cnt = 0; m_lit = 0;
    m_armed = 0; m_off = 0; m_sofd = 0; m_out = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
  endtask

  // Driver: apply one pixel at the negedge, advance one clock, then check all outputs.
  task automatic step(input bit sof, input int px, input int py,
                      input int tlx, input int tly, input int dig);
    bit e;
    bit lit_now;
    startOfFrame = sof;
    pixelX = px[10:0]; pixelY = py[10:0];
    topLeftX = tlx[10:0]; topLeftY = tly[10:0]; digit = dig[3:0];
    e = m_armed && model_lit(px - m_sx, py - m_sy, m_dig);
    @(posedge clk);
    lit_now = m_out;
    if (m_sofd)
      m_off = (m_sx + 15 < 0) || (m_sx > 639) || (m_sy + 31 < 0) || (m_sy > 479);
    m_sofd = sof;
    if (sof) begin
      m_lit = m_cnt;
      m_cnt = lit_now ? 1 : 0;
      m_sx = tlx; m_sy = tly; m_dig = dig; m_armed = 1;
    end else if (lit_now && m_cnt < 1023) begin
      m_cnt++;
    end
    exp_q.push_back(e);
    m_out = exp_q.pop_front();
    #1;
    check("draw", drawingRequest, m_out);
    check("rgb", RGBout, m_out ? 8'h1C : 8'hFF);
    check("litCount", litCount, m_lit);
    check("offScreen", offScreen, m_off);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, -500, -500, $urandom_range(0, 700) - 40, $urandom_range(0, 500) - 40, $urandom_range(0, 15));
  endtask

  task automatic sof_at(input int tlx, input int tly, input int dig);
    step(1, -500, -500, tlx, tly, dig);
  endtask

  // Raster over the shadow box. The placement inputs keep changing, but they must not take effect mid-frame.
  task automatic scan(input int bx, input int by);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 16; x++)
        step(0, bx + x, by + y, $urandom_range(0, 700) - 40, $urandom_range(0, 500) - 40,
             $urandom_range(0, 15));
  endtask

  task automatic pulse_reset();
    #2 resetN = 1'b0;
    #1;
    check("rst_draw", drawingRequest, 1'b0);
    check("rst_rgb", RGBout, 8'hFF);
    check("rst_lit", litCount, 10'd0);
    check("rst_off", offScreen, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  // Stimulus and final report
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_draw", drawingRequest, 1'b0);
    check("reset_rgb", RGBout, 8'hFF);
    check("reset_lit", litCount, 10'd0);
    check("reset_off", offScreen, 1'b0);
    @(negedge clk);
    resetN = 1'b1;

    // No drawing before the first frame start, even inside the default box.
    for (int i = 0; i < 6; i++) step(0, 2 + i, 1, 0, 0, 8);

    // Single-pixel latency at (100,50).
    sof_at(100, 50, 8);
    step(0, 102, 50, 0, 0, 1);
    step(0, 101, 50, 0, 0, 1);
    idle(); idle();

    // Full-box counts for digits 1 and 8.
    sof_at(0, 0, 1);
    scan(0, 0);
    idle(); idle();
    sof_at(0, 0, 8);
    check("lit_digit1", litCount, 10'd84);
    scan(0, 0);
    idle(); idle();
    sof_at(0, 0, 8);
    check("lit_digit8", litCount, count_box(8));

    // Saturation across four scans in one frame.
    for (int k = 0; k < 4; k++) scan(0, 0);
    idle(); idle();
    sof_at(-20, 10, 3);
    check("lit_sat", litCount, 10'd1023);
    idle();
    check("off_left", offScreen, 1'b1);
    scan(-20, 10);
    sof_at(-5, 10, 8);
    idle();
    check("off_partial", offScreen, 1'b0);
    scan(-5, 10);

    // A lit pixel on the frame-start cycle is counted in the new frame.
    sof_at(100, 50, 8);
    idle(); idle();
    step(0, 102, 50, 0, 0, 0);
    idle();
    sof_at(100, 50, 8);
    check("sof_old_frame", litCount, 10'd0);
    idle(); idle();
    sof_at(100, 50, 8);
    check("sof_new_frame", litCount, 10'd1);

    // Reset while a pixel is being drawn.
    idle(); idle();
    step(0, 102, 50, 0, 0, 0);
    idle();
    check("pre_reset_draw", drawingRequest, 1'b1);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(0, 102 + i, 50, 100, 50, 8);
    check("post_reset_lit", litCount, 10'd0);

    // Randomized traffic around the current box.
    sof_at(300, 200, 8);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        sof_at($urandom_range(0, 700) - 40, $urandom_range(0, 520) - 40, $urandom_range(0, 15));
      else
        step(0, m_sx + $urandom_range(0, 23) - 4, m_sy + $urandom_range(0, 39) - 4,
             $urandom_range(0, 700) - 40, $urandom_range(0, 520) - 40, $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
